// File: rtl/score_update_ctrl.sv
// rtl/score_update_ctrl.sv - BCD score / miss counter sequencer with frame-committed display word
//
// Purpose:
//   Owns the 3-digit BCD score and the miss counter that feed the score overlay.
//   Game-logic hits are queued and applied one digit per cycle by a small carry
//   FSM. Misses bump a saturating counter. CPU writes load or clear everything.
//   A display word is published only on the frame tick, and only while the FSM
//   is idle, so the overlay never shows a partially carried score.
//
// Ports:
//   clk          system clock, all logic on posedge
//   res          synchronous active-high reset
//   hit, miss    1-cycle tile event pulses
//   write_en0    register write strobe
//   right_addr   address decode for this block
//   pwdata       write data: [31] clear-all, [11:0] BCD score load value
//   animate      1-cycle frame tick
//   disp_word    {ovf, drop, game_over, 5'd0, miss_cnt, 4'd0, score_bcd}, frame-committed
//   score_bcd    live BCD score {d2, d1, d0}
//   miss_cnt     live miss count, saturating at MAX_MISS
//   pend_cnt     queued hits not yet applied
//   busy         carry FSM is not idle
//   game_over    miss_cnt has reached MAX_MISS
module score_update_ctrl #(
    parameter int PEND_W   = 4,
    parameter int MAX_MISS = 3
) (
    input  logic              clk,
    input  logic              res,
    input  logic              hit,
    input  logic              miss,
    input  logic              write_en0,
    input  logic              right_addr,
    input  logic [31:0]       pwdata,
    input  logic              animate,
    output logic [31:0]       disp_word,
    output logic [11:0]       score_bcd,
    output logic [7:0]        miss_cnt,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              busy,
    output logic              game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INC0 = 2'd1,
        INC1 = 2'd2,
        INC2 = 2'd3
    } state_t;

    localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
    localparam logic [7:0]        MISS_MAX = 8'(MAX_MISS);

    state_t state;
    logic   ovf;
    logic   drop;

    logic cpu_wr;
    logic hit_ok;
    logic miss_ok;
    logic deq;
    logic pend_full;
    logic at_max;

    assign cpu_wr    = write_en0 & right_addr;
    assign game_over = (miss_cnt == MISS_MAX);
    assign busy      = (state != IDLE);
    assign hit_ok    = hit & ~game_over;
    assign miss_ok   = miss & ~game_over;
    assign deq       = (state == IDLE) && (pend_cnt != '0);
    assign pend_full = &pend_cnt;
    assign at_max    = (score_bcd == 12'h999);

    function automatic logic [3:0] clamp9(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    always_ff @(posedge clk) begin
        if (res) begin
            state     <= IDLE;
            score_bcd <= '0;
            miss_cnt  <= '0;
            pend_cnt  <= '0;
            ovf       <= 1'b0;
            drop      <= 1'b0;
            disp_word <= '0;
        end else begin
            // Commit samples the pre-update values, including on a coincident cpu write.
            if (animate && state == IDLE) begin
                disp_word <= {ovf, drop, game_over, 5'd0, miss_cnt, 4'd0, score_bcd};
            end

            if (cpu_wr) begin
                state    <= IDLE;
                pend_cnt <= '0;
                ovf      <= 1'b0;
                drop     <= 1'b0;
                if (pwdata[31]) begin
                    score_bcd <= '0;
                    miss_cnt  <= '0;
                end else begin
                    score_bcd <= {clamp9(pwdata[11:8]), clamp9(pwdata[7:4]), clamp9(pwdata[3:0])};
                end
            end else begin
                // game_over being low guarantees miss_cnt < MAX_MISS here.
                if (miss_ok) begin
                    miss_cnt <= miss_cnt + 8'd1;
                end

                // A hit coinciding with a dequeue is accepted even when full: net zero.
                if (hit_ok && !deq) begin
                    if (pend_full) begin
                        drop <= 1'b1;
                    end else begin
                        pend_cnt <= pend_cnt + PEND_ONE;
                    end
                end else if (!hit_ok && deq) begin
                    pend_cnt <= pend_cnt - PEND_ONE;
                end

                case (state)
                    IDLE: begin
                        if (deq) begin
                            if (at_max) begin
                                ovf <= 1'b1;
                            end else begin
                                state <= INC0;
                            end
                        end
                    end
                    INC0: begin
                        if (score_bcd[3:0] == 4'd9) begin
                            score_bcd[3:0] <= 4'd0;
                            state          <= INC1;
                        end else begin
                            score_bcd[3:0] <= score_bcd[3:0] + 4'd1;
                            state          <= IDLE;
                        end
                    end
                    INC1: begin
                        if (score_bcd[7:4] == 4'd9) begin
                            score_bcd[7:4] <= 4'd0;
                            state          <= INC2;
                        end else begin
                            score_bcd[7:4] <= score_bcd[7:4] + 4'd1;
                            state          <= IDLE;
                        end
                    end
                    default: begin
                        // d2 cannot be 9 here: 999 is caught before leaving IDLE.
                        score_bcd[11:8] <= score_bcd[11:8] + 4'd1;
                        state           <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
